ps2_scan_receiver: RTL and testbench

//  Receives PS/2 keyboard frames on ps2c/ps2d and delivers make-code bytes to the input register (INPR).

---
 rtl/ps2_scan_receiver.sv | 154 +++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver
//   Receives PS/2 keyboard frames and hands make-code bytes to the input register.
//   Each byte is held until the control path acknowledges it.
//   Overrun, parity, stop-bit and timeout errors are reported as one-cycle pulses.
//
// Ports
//   clk                 system clock; every register updates on the rising edge
//   reset               asynchronous, active-low reset
//   ps2c, ps2d          PS/2 clock and data pins, asynchronous to clk
//   ack                 one-cycle pulse: keyboard_input has been consumed
//   keyboard_input      last delivered scan code
//   input_arrived_flag  high while keyboard_input holds an unacknowledged byte
//   overrun             one-cycle pulse: a good byte was dropped because the holding register was full
//   frame_err           one-cycle pulse: parity error, stop-bit error or timeout
module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter bit SUPPRESS_BREAK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       ack,
    output logic [7:0] keyboard_input,
    output logic       input_arrived_flag,
    output logic       overrun,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          c_s1, c_s2, d_s1, d_s2;
    logic          ps2c_f, ps2c_fd;
    logic [3:0]    filt_cnt;
    logic          strobe;
    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          break_pending;
    logic          frame_good;

    // Synchronizers and clock glitch filter. Both pins idle high.
    // The filtered clock follows the synchronized clock only after FILTER_LEN
    // consecutive samples that disagree with its current value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_s1     <= 1'b1;
            c_s2     <= 1'b1;
            d_s1     <= 1'b1;
            d_s2     <= 1'b1;
            ps2c_f   <= 1'b1;
            ps2c_fd  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            c_s1    <= ps2c;
            c_s2    <= c_s1;
            d_s1    <= ps2d;
            d_s2    <= d_s1;
            ps2c_fd <= ps2c_f;
            if (c_s2 == ps2c_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
                ps2c_f   <= c_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Bit strobe: falling edge of the filtered clock.
    assign strobe = ps2c_fd & ~ps2c_f;

    // Odd parity across data + parity bit, and a high stop bit sampled now.
    assign frame_good = (^{shreg, par_bit}) & d_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            bitcnt             <= '0;
            shreg              <= '0;
            par_bit            <= 1'b0;
            tcnt               <= '0;
            break_pending      <= 1'b0;
            keyboard_input     <= '0;
            input_arrived_flag <= 1'b0;
            overrun            <= 1'b0;
            frame_err          <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            // Acknowledge clears the flag; a delivery in the same cycle overrides.
            if (ack) input_arrived_flag <= 1'b0;

            case (state)
                IDLE: begin
                    if (strobe && !d_s2) begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end
                end
                DATA: begin
                    if (strobe) begin
                        shreg  <= {d_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (strobe) begin
                        par_bit <= d_s2;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (strobe) begin
                        state <= IDLE;
                        if (!frame_good) begin
                            frame_err <= 1'b1;
                        end else if (SUPPRESS_BREAK && break_pending) begin
                            break_pending <= 1'b0;
                        end else if (SUPPRESS_BREAK && shreg == 8'hF0) begin
                            break_pending <= 1'b1;
                        end else if (!input_arrived_flag || ack) begin
                            keyboard_input     <= shreg;
                            input_arrived_flag <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame timeout. Only acts on cycles without a strobe, so a strobe
            // landing on the expiry cycle keeps the frame alive.
            if (state == IDLE || strobe) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                tcnt      <= '0;
                state     <= IDLE;
                frame_err <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;

    localparam int FL   = 8;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic clk = 1'b0, reset = 1'b0, ps2c = 1'b1, ps2d = 1'b1, ack = 1'b0;
    logic [7:0] kb, kb_r;
    logic flag, flag_r, ovr, ovr_r, ferr, ferr_r;

    ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .SUPPRESS_BREAK(1'b1)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .ack(ack),
        .keyboard_input(kb), .input_arrived_flag(flag), .overrun(ovr), .frame_err(ferr));

    ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .SUPPRESS_BREAK(1'b0)) dut_raw (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .ack(ack),
        .keyboard_input(kb_r), .input_arrived_flag(flag_r), .overrun(ovr_r), .frame_err(ferr_r));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int err_cnt = 0, ovr_cnt = 0, fall_cnt = 0;
    logic [7:0] q_main[$], q_raw[$];
    logic       pflag = 1'b0, pflag_r = 1'b0;
    logic [7:0] pkb = '0, pkb_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a new byte appears when the flag rises or the held byte changes.
    always @(negedge clk) begin
        if (reset) begin
            if (ferr) err_cnt++;
            if (ovr) ovr_cnt++;
            if (pflag && !flag) fall_cnt++;
            if (flag && (!pflag || kb != pkb)) begin
                n_checks++;
                if (q_main.size() == 0) begin
                    n_fail++;
                    $display("FAIL main_unexpected: got %0h expected none", kb);
                end else begin
                    logic [7:0] e;
                    e = q_main.pop_front();
                    if (kb !== e) begin
                        n_fail++;
                        $display("FAIL main_byte: got %0h expected %0h", kb, e);
                    end
                end
            end
            if (flag_r && (!pflag_r || kb_r != pkb_r)) begin
                n_checks++;
                if (q_raw.size() == 0) begin
                    n_fail++;
                    $display("FAIL raw_unexpected: got %0h expected none", kb_r);
                end else begin
                    logic [7:0] e;
                    e = q_raw.pop_front();
                    if (kb_r !== e) begin
                        n_fail++;
                        $display("FAIL raw_byte: got %0h expected %0h", kb_r, e);
                    end
                end
            end
        end
        pflag = flag; pkb = kb; pflag_r = flag_r; pkb_r = kb_r;
    end

    task automatic send_bit(input logic b);
        @(posedge clk); #1 ps2d = b;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b1;
    endtask

    // Start bit plus the first n data bits, LSB first.
    task automatic send_partial(input logic [7:0] d, input int n);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    // Full frame. The stop-bit strobe falls FL+3 edges after the pin edge
    // (2 sync + FL filter + 1 fall detect); ack_stop drives ack in exactly that cycle.
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop,
                              input logic ack_stop, input logic chk_lat);
        send_partial(d, 8);
        send_bit(~^d ^ par_bad);
        @(posedge clk); #1 ps2d = stop;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(posedge clk); #1;
            if (i == FL + 2) begin
                if (ack_stop) ack = 1'b1;
                if (chk_lat) check("latency_flag_low", flag, 1'b0);
            end
            if (i == FL + 3) begin
                ack = 1'b0;
                if (chk_lat) begin
                    check("latency_flag_high", flag, 1'b1);
                    check("latency_kb", kb, d);
                end
            end
        end
        #1 ps2c = 1'b1; ps2d = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_bad;
        logic       stop;
        logic       exp_del;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int e0, o0, f0;
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h32, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hE0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_kb", kb, 8'h00);
        check("reset_flag", flag, 1'b0);
        check("reset_ovr_err", {ovr, ferr}, 2'b00);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);

        // Exact pin-to-flag latency, flag held until ack.
        q_main.push_back(8'h1C); q_raw.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (50) @(posedge clk); #1;
        check("flag_held", flag, 1'b1);
        pulse_ack(); #1;
        check("flag_after_ack", flag, 1'b0);
        check("kb_kept_after_ack", kb, 8'h1C);

        // Table-driven frames.
        foreach (vecs[i]) begin
            e0 = err_cnt;
            if (vecs[i].exp_del) begin
                q_main.push_back(vecs[i].data); q_raw.push_back(vecs[i].data);
            end
            send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop, 1'b0, 1'b0);
            #1;
            check($sformatf("vec%0d_flag", i), flag, vecs[i].exp_del);
            check($sformatf("vec%0d_err", i), err_cnt - e0, {31'd0, vecs[i].exp_err});
            pulse_ack(); #1;
            check($sformatf("vec%0d_flag_cleared", i), flag, 1'b0);
        end

        // Break suppression: main sees only the final 1C, raw sees all three.
        q_main.push_back(8'h1C);
        q_raw.push_back(8'hF0); q_raw.push_back(8'h1C); q_raw.push_back(8'h1C);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        check("break_f0_no_flag", flag, 1'b0);
        pulse_ack();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        check("break_code_no_flag", flag, 1'b0);
        pulse_ack();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        check("after_break_flag", flag, 1'b1);
        pulse_ack();

        // Overrun without ack.
        o0 = ovr_cnt;
        q_main.push_back(8'h1C); q_raw.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        check("overrun_kb", kb, 8'h1C);
        check("overrun_count", ovr_cnt - o0, 1);
        pulse_ack();

        // Ack in the stop-strobe cycle: new byte replaces old, flag never drops.
        q_main.push_back(8'h1C); q_raw.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        o0 = ovr_cnt; f0 = fall_cnt;
        q_main.push_back(8'h32); q_raw.push_back(8'h32);
        send_frame(8'h32, 1'b0, 1'b1, 1'b1, 1'b0); #1;
        check("ackstop_kb", kb, 8'h32);
        check("ackstop_flag", flag, 1'b1);
        check("ackstop_no_drop", fall_cnt - f0, 0);
        check("ackstop_no_overrun", ovr_cnt - o0, 0);
        pulse_ack();

        // Short clock glitch with data low: must not start a frame.
        e0 = err_cnt;
        @(posedge clk); #1 ps2d = 1'b0; ps2c = 1'b0;
        repeat (FL - 1) @(posedge clk);
        #1 ps2c = 1'b1;
        repeat (TO + 100) @(posedge clk);
        #1 ps2d = 1'b1;
        check("glitch_no_err", err_cnt - e0, 0);

        // Stall mid-frame past the timeout.
        send_partial(8'hA5, 4);
        repeat (TO + 100) @(posedge clk); #1;
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_no_flag", flag, 1'b0);
        q_main.push_back(8'h2A); q_raw.push_back(8'h2A);
        send_frame(8'h2A, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        check("after_timeout_kb", kb, 8'h2A);
        check("after_timeout_err", err_cnt - e0, 1);

        // Reset in the middle of a frame.
        send_partial(8'h77, 4);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("midreset_kb", kb, 8'h00);
        check("midreset_flag", flag, 1'b0);
        check("midreset_pulses", {ovr, ferr}, 2'b00);
        ps2c = 1'b1; ps2d = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        q_main.push_back(8'h45); q_raw.push_back(8'h45);
        send_frame(8'h45, 1'b0, 1'b1, 1'b0, 1'b0); #1;
        check("postreset_kb", kb, 8'h45);
        check("postreset_flag", flag, 1'b1);

        repeat (10) @(posedge clk);
        check("main_queue_drained", q_main.size(), 0);
        check("raw_queue_drained", q_raw.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
